// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FAULT  = 2'd1,
    PARKED = 2'd2
  } fetch_state_e;

  // Queue pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: PC and instruction storage with allocate, fill and pop pointers.
// Also computes the head entry as it will look after the current edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             fill_en,
  input  logic [XLEN-1:0]  fill_data,
  input  logic             pop,
  output logic [PTR_W-1:0] used_c,
  output logic [PTR_W-1:0] inflight_c,
  output logic             head_valid_c,
  output logic             nxt_valid_c,
  output logic [XLEN-1:0]  nxt_pc_c,
  output logic [XLEN-1:0]  nxt_insn_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] fill_nxt;
  logic [IDX_W-1:0] nxt_idx;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  // Pointer registers; a flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (alloc)   wr_ptr   <= wr_ptr + PTR_W'(1);
      if (fill_en) fill_ptr <= fill_ptr + PTR_W'(1);
      if (pop)     rd_ptr   <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: a slot is only read once its fill pointer has passed it.
  always_ff @(posedge clk) begin
    if (alloc)   pc_mem[wr_ptr[IDX_W-1:0]]     <= alloc_pc;
    if (fill_en) data_mem[fill_ptr[IDX_W-1:0]] <= fill_data;
  end

  assign used_c       = wr_ptr - rd_ptr;
  assign inflight_c   = wr_ptr - fill_ptr;
  assign head_valid_c = (fill_ptr != rd_ptr);

  // Look-ahead head, bypassing a fill that lands in the new head slot this cycle.
  always_comb begin
    rd_nxt      = rd_ptr + PTR_W'(pop);
    fill_nxt    = fill_ptr + PTR_W'(fill_en);
    nxt_idx     = rd_nxt[IDX_W-1:0];
    nxt_valid_c = !flush && (fill_nxt != rd_nxt);
    nxt_pc_c    = pc_mem[nxt_idx];
    nxt_insn_c  = data_mem[nxt_idx];
    if (fill_en && (fill_ptr == rd_nxt)) nxt_insn_c = fill_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, pipelined imem requests, prefetch queue, redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to turn misaligned redirect targets into a fault marker.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc,
  output logic            insn_fault,
  input  logic            insn_ready
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] drop;
  logic [XLEN-1:0]  insn_q;
  logic [XLEN-1:0]  insn_pc_q;
  logic             fault_q;

  logic [PTR_W-1:0] used_c;
  logic [PTR_W-1:0] inflight_c;
  logic             head_valid_c;
  logic             nxt_valid_c;
  logic [XLEN-1:0]  nxt_pc_c;
  logic [XLEN-1:0]  nxt_insn_c;

  logic [XLEN-1:0]  target_c;
  logic             misaligned_c;
  logic [OCC_W-1:0] occ_c;
  logic             grant_c;
  logic             fill_en_c;
  logic             drop_hit_c;
  logic             pop_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_c     = redirect_pc;
  assign misaligned_c = |redirect_pc[1:0];
`else
  assign target_c     = redirect_pc & ~XLEN'(3);
  assign misaligned_c = 1'b0;
`endif

  // Slots reserved for stale responses count against capacity like live entries.
  always_comb begin
    occ_c      = OCC_W'(used_c) + OCC_W'(drop);
    grant_c    = imem_req && imem_gnt;
    drop_hit_c = imem_rvalid && (drop != '0);
    fill_en_c  = imem_rvalid && (drop == '0);
    pop_c      = (state == RUN) && head_valid_c && insn_ready;
  end

  assign imem_req   = rst_n && (state == RUN) && !redirect && (occ_c < OCC_W'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign insn_valid = (state == FAULT) || ((state == RUN) && head_valid_c);
  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_fault = fault_q;

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (redirect),
    .alloc        (grant_c),
    .alloc_pc     (fetch_pc),
    .fill_en      (fill_en_c),
    .fill_data    (imem_rdata),
    .pop          (pop_c),
    .used_c       (used_c),
    .inflight_c   (inflight_c),
    .head_valid_c (head_valid_c),
    .nxt_valid_c  (nxt_valid_c),
    .nxt_pc_c     (nxt_pc_c),
    .nxt_insn_c   (nxt_insn_c)
  );

  // FSM, fetch PC, drop counter and the registered head presented to decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      drop      <= '0;
      insn_q    <= '0;
      insn_pc_q <= '0;
      fault_q   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= target_c;
      drop     <= PTR_W'(drop + inflight_c - PTR_W'(imem_rvalid));
      if (misaligned_c) begin
        state     <= FAULT;
        insn_q    <= XLEN'(NOP_INSN);
        insn_pc_q <= target_c;
        fault_q   <= 1'b1;
      end else begin
        state   <= RUN;
        fault_q <= 1'b0;
      end
    end else begin
      if (grant_c)    fetch_pc <= fetch_pc + XLEN'(4);
      if (drop_hit_c) drop     <= drop - PTR_W'(1);
      case (state)
        RUN: begin
          if (nxt_valid_c) begin
            insn_q    <= nxt_insn_c;
            insn_pc_q <= nxt_pc_c;
          end
        end
        FAULT: begin
          if (insn_ready) begin
            state   <= PARKED;
            fault_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem responder of configurable latency.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_fault;
  logic        insn_ready;

  int vec_cnt = 0;
  int err_cnt = 0;
  int lat;
  int cyc = 0;
  int grant_cnt = 0;
  int grant_base;
  bit gnt_en;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .insn_valid  (insn_valid),
    .insn        (insn),
    .insn_pc     (insn_pc),
    .insn_fault  (insn_fault),
    .insn_ready  (insn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  function automatic logic [31:0] redirect_target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    assert (obs === exp_v)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // In-order memory: grant seen in cycle c returns data in cycle c+lat.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
    end else begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
        grant_cnt++;
      end
      check("outstanding_le_depth", 32'(pend_addr.size() <= DEPTH), 32'd1);
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr[0]);
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Every instruction handed to decode must follow the current stream in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 32'h0;
    end else begin
      if (insn_valid && insn_ready) begin
        if (insn_fault) begin
          check("pop_fault_insn", insn, NOP);
          check("pop_fault_pc", insn_pc, exp_pc);
        end else begin
          check("pop_pc", insn_pc, exp_pc);
          check("pop_insn", insn, mem_word(insn_pc));
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect) exp_pc = redirect_target(redirect_pc);
    end
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    insn_ready  = 1'b1;
    gnt_en      = 1'b1;
    lat         = 1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    step();
    step();
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", insn_valid, 32'd0);
    check("rst_insn", insn, 32'h0);
    check("rst_pc", insn_pc, 32'h0);
    check("rst_fault", insn_fault, 32'd0);

    // Zero-wait streaming from reset.
    rst_n = 1'b1;
    #1;
    check("c0_req", imem_req, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    step();
    check("c1_addr", imem_addr, 32'h4);
    check("c1_valid", insn_valid, 32'd0);
    step();
    check("c2_addr", imem_addr, 32'h8);
    check("c2_valid", insn_valid, 32'd1);
    check("c2_insn", insn, 32'h11);
    check("c2_pc", insn_pc, 32'h0);
    step();
    check("c3_addr", imem_addr, 32'hC);
    check("c3_insn", insn, 32'h22);
    check("c3_pc", insn_pc, 32'h4);

    // One-cycle reset mid-stream.
    rst_n      = 1'b0;
    insn_ready = 1'b0;
    #1;
    check("mid_rst_req", imem_req, 32'd0);
    step();
    check("mid_rst_valid", insn_valid, 32'd0);
    check("mid_rst_insn", insn, 32'h0);
    check("mid_rst_pc", insn_pc, 32'h0);
    check("mid_rst_fault", insn_fault, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);

    // Decode stalled: queue fills to DEPTH and requests stop.
    rst_n      = 1'b1;
    grant_base = grant_cnt;
    #1;
    check("restart_req", imem_req, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    step();
    step();
    step();
    step();
    check("full_req_c8", imem_req, 32'd0);
    step();
    check("full_req_c9", imem_req, 32'd0);
    check("full_valid", insn_valid, 32'd1);
    check("full_head_pc", insn_pc, 32'h0);
    check("full_head_insn", insn, 32'h11);
    check("full_grants", 32'(grant_cnt - grant_base), 32'd4);
    insn_ready = 1'b1;
    step();
    check("unstall_req", imem_req, 32'd1);
    check("unstall_addr", imem_addr, 32'h10);
    check("unstall_pc", insn_pc, 32'h4);
    check("unstall_insn", insn, 32'h22);
    step();

    // Latency 3, redirect to 0x100 with three responses in flight.
    rst_n = 1'b0;
    lat   = 3;
    step();
    rst_n = 1'b1;
    #1;
    check("l3_r0_addr", imem_addr, 32'h0);
    step();
    step();
    step();
    check("l3_r3_req", imem_req, 32'd1);
    check("l3_r3_addr", imem_addr, 32'hC);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("redir_req_low", imem_req, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("r4_req", imem_req, 32'd1);
    check("r4_addr", imem_addr, 32'h100);
    check("r4_valid", insn_valid, 32'd0);
    step();
    check("r5_valid", insn_valid, 32'd0);
    step();
    check("r6_valid", insn_valid, 32'd0);
    step();
    check("r7_valid", insn_valid, 32'd0);
    step();
    check("r8_valid", insn_valid, 32'd1);
    check("r8_pc", insn_pc, 32'h100);
    check("r8_insn", insn, 32'h451);
    check("r8_full_req", imem_req, 32'd0);
    step();
    check("r9_pc", insn_pc, 32'h104);
    check("r9_insn", insn, 32'h462);
    check("r9_addr", imem_addr, 32'h110);

    // Redirect together with a response and a pop.
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    #1;
    check("r9_redir_req", imem_req, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("r10_valid", insn_valid, 32'd0);
    check("r10_hold_pc", insn_pc, 32'h104);
    check("r10_hold_insn", insn, 32'h462);
    check("r10_req", imem_req, 32'd1);
    check("r10_addr", imem_addr, 32'h300);
    step();
    step();
    step();
    step();
    check("r14_valid", insn_valid, 32'd1);
    check("r14_pc", insn_pc, 32'h300);
    check("r14_insn", insn, 32'hCD1);
    check("r14_req", imem_req, 32'd0);

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    insn_ready  = 1'b0;
    step();
    redirect = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("flt_valid", insn_valid, 32'd1);
    check("flt_fault", insn_fault, 32'd1);
    check("flt_pc", insn_pc, 32'h102);
    check("flt_insn", insn, NOP);
    check("flt_req", imem_req, 32'd0);
    step();
    check("flt_hold_valid", insn_valid, 32'd1);
    check("flt_hold_fault", insn_fault, 32'd1);
    check("flt_hold_req", imem_req, 32'd0);
    insn_ready = 1'b1;
    step();
    check("park_valid", insn_valid, 32'd0);
    check("park_req", imem_req, 32'd0);
    step();
    check("park_req2", imem_req, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    #1;
    check("resume_req", imem_req, 32'd1);
    check("resume_addr", imem_addr, 32'h200);
    check("resume_valid", insn_valid, 32'd0);
    step();
    step();
    step();
    step();
    check("resume_head_valid", insn_valid, 32'd1);
    check("resume_head_pc", insn_pc, 32'h200);
    check("resume_head_insn", insn, 32'h891);
    check("resume_head_fault", insn_fault, 32'd0);
`else
    check("align_req", imem_req, 32'd1);
    check("align_addr", imem_addr, 32'h100);
    check("align_valid", insn_valid, 32'd0);
    check("align_fault", insn_fault, 32'd0);
    step();
    insn_ready = 1'b1;
    step();
    step();
    step();
    check("align_head_valid", insn_valid, 32'd1);
    check("align_head_pc", insn_pc, 32'h100);
    check("align_head_insn", insn, 32'h451);
    check("align_head_fault", insn_fault, 32'd0);
    check("align_full_req", imem_req, 32'd0);
`endif
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
